// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the dmem_sync data memory.
// Parity storage is compiled in only when DMEM_PARITY_EN is defined.
package dmem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } dmem_state_t;

`ifdef DMEM_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // One storage lane per data byte, optionally carrying its parity bit on top
  localparam int LANE_W = 8 + PAR_BITS;

  function automatic int calc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int calc_nbytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int parity_width(input int nbytes);
    return nbytes * PAR_BITS;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-lane storage array: synchronous per-lane write, registered 1-cycle read.
// The array itself is never reset; only the read register is.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int NLANES = 1,
  parameter int ADDR_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we_i,
  input  logic                          re_i,
  input  logic [NLANES-1:0]             lane_we_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [NLANES-1:0][LANE_W-1:0] wdata_i,
  output logic [NLANES-1:0][LANE_W-1:0] rdata_o
);

  localparam int DEPTH = calc_depth(ADDR_W);

  logic [NLANES-1:0][LANE_W-1:0] mem_q [DEPTH];
  logic [NLANES-1:0][LANE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NLANES; b++) begin
        if (lane_we_i[b]) mem_q[addr_i][b] <= wdata_i[b];
      end
    end
  end

  // Holds its value between reads so the response data stays stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_sync.sv
// Synchronous data memory with valid/ready request port, init sequencer and
// optional per-byte even parity (enabled by defining DMEM_PARITY_EN).
module dmem_sync
  import dmem_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [DATA_W/8-1:0]  req_be,
  input  logic                 req_perr_inj,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_perr,
  output logic                 init_busy
);

  localparam int NBYTES = calc_nbytes(DATA_W);

  dmem_state_t state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic req_ready_q;
  logic init_busy_q;
  logic rsp_valid_q;
  logic req_fire;

  logic arr_we;
  logic arr_re;
  logic [NBYTES-1:0] arr_lane_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [NBYTES-1:0][LANE_W-1:0] arr_wdata;
  logic [NBYTES-1:0][LANE_W-1:0] arr_rdata;

  assign req_fire = req_valid & req_ready_q;

  // A request arriving with clear is still accepted; INIT begins on the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + ADDR_W'(1);
          if (init_cnt_q == {ADDR_W{1'b1}}) begin
            state_q     <= READY;
            req_ready_q <= 1'b1;
            init_busy_q <= 1'b0;
          end
        end
        READY: begin
          if (clear) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            req_ready_q <= 1'b0;
            init_busy_q <= 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // The init sequencer owns the array port while INIT; otherwise the CPU request does
  always_comb begin
    arr_we      = 1'b0;
    arr_re      = 1'b0;
    arr_lane_we = '0;
    arr_addr    = req_addr;
    arr_wdata   = '0;
    if (state_q == INIT) begin
      arr_we      = 1'b1;
      arr_addr    = init_cnt_q;
      arr_lane_we = '1;
      for (int b = 0; b < NBYTES; b++) begin
`ifdef DMEM_PARITY_EN
        arr_wdata[b] = {^INIT_VAL[b*8 +: 8], INIT_VAL[b*8 +: 8]};
`else
        arr_wdata[b] = INIT_VAL[b*8 +: 8];
`endif
      end
    end else if (req_fire) begin
      arr_we      = req_we;
      arr_re      = ~req_we;
      arr_lane_we = req_be;
      for (int b = 0; b < NBYTES; b++) begin
`ifdef DMEM_PARITY_EN
        arr_wdata[b] = {(^req_wdata[b*8 +: 8]) ^ req_perr_inj, req_wdata[b*8 +: 8]};
`else
        arr_wdata[b] = req_wdata[b*8 +: 8];
`endif
      end
    end
  end

  dmem_array #(
    .NLANES (NBYTES),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (arr_we),
    .re_i      (arr_re),
    .lane_we_i (arr_lane_we),
    .addr_i    (arr_addr),
    .wdata_i   (arr_wdata),
    .rdata_o   (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_valid_q <= 1'b0;
    else rsp_valid_q <= req_fire & ~req_we;
  end

  always_comb begin
    rsp_rdata = '0;
    for (int b = 0; b < NBYTES; b++) begin
      rsp_rdata[b*8 +: 8] = arr_rdata[b][7:0];
    end
  end

`ifdef DMEM_PARITY_EN
  logic [NBYTES-1:0] lane_err;

  always_comb begin
    lane_err = '0;
    for (int b = 0; b < NBYTES; b++) begin
      lane_err[b] = ^arr_rdata[b];
    end
  end

  assign rsp_perr = rsp_valid_q & (|lane_err);
`else
  logic unused_perr_inj;

  assign unused_perr_inj = req_perr_inj;
  assign rsp_perr        = 1'b0;
`endif

  assign req_ready = req_ready_q;
  assign init_busy = init_busy_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_dmem_sync.sv
// Directed self-checking bench for dmem_sync: an 8-bit instance and a 32-bit
// instance with a non-zero INIT_VAL; parity checks follow DMEM_PARITY_EN.
module tb_dmem_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  logic        d8_valid, d8_ready, d8_we, d8_inj, d8_rvalid, d8_perr, d8_busy;
  logic [3:0]  d8_addr;
  logic [7:0]  d8_wdata, d8_rdata;
  logic [0:0]  d8_be;

  logic        d32_valid, d32_ready, d32_we, d32_inj, d32_rvalid, d32_perr, d32_busy;
  logic [3:0]  d32_addr;
  logic [31:0] d32_wdata, d32_rdata;
  logic [3:0]  d32_be;

  int checks = 0;
  int errors = 0;
  logic [7:0] model8 [16];

  always #5 clk = ~clk;

  dmem_sync #(.DATA_W(8), .ADDR_W(4), .INIT_VAL(8'h00)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(d8_valid), .req_ready(d8_ready), .req_we(d8_we),
    .req_addr(d8_addr), .req_wdata(d8_wdata), .req_be(d8_be),
    .req_perr_inj(d8_inj), .rsp_valid(d8_rvalid), .rsp_rdata(d8_rdata),
    .rsp_perr(d8_perr), .init_busy(d8_busy)
  );

  dmem_sync #(.DATA_W(32), .ADDR_W(4), .INIT_VAL(32'hDEADBEEF)) dut32 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(d32_valid), .req_ready(d32_ready), .req_we(d32_we),
    .req_addr(d32_addr), .req_wdata(d32_wdata), .req_be(d32_be),
    .req_perr_inj(d32_inj), .rsp_valid(d32_rvalid), .rsp_rdata(d32_rdata),
    .rsp_perr(d32_perr), .init_busy(d32_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [3:0] a,
                               input logic [7:0] wd, input logic be, input logic inj);
    d8_valid = v; d8_we = we; d8_addr = a; d8_wdata = wd; d8_be = be; d8_inj = inj;
  endtask

  task automatic applyWide(input logic v, input logic we, input logic [3:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
    d32_valid = v; d32_we = we; d32_addr = a; d32_wdata = wd; d32_be = be; d32_inj = 1'b0;
  endtask

  // Counts edges until the 8-bit instance raises req_ready; a timeout shows as a wrong count
  task automatic waitReady(input string tag);
    int cnt;
    cnt = 0;
    while (cnt < 100 && d8_ready !== 1'b1) begin
      checkOutput({tag, "_busy"}, d8_busy, 1'b1);
      stepCycle();
      cnt++;
    end
    checkOutput({tag, "_cycles"}, cnt, 16);
    checkOutput({tag, "_busy_done"}, d8_busy, 1'b0);
    checkOutput({tag, "_ready32"}, d32_ready, 1'b1);
  endtask

  task automatic read8(input string tag, input logic [3:0] a, input logic [7:0] exp);
    applyStimulus(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    checkOutput({tag, "_valid"}, d8_rvalid, 1'b1);
    checkOutput({tag, "_data"}, d8_rdata, exp);
  endtask

  task automatic write8(input logic [3:0] a, input logic [7:0] wd, input logic be, input logic inj);
    applyStimulus(1'b1, 1'b1, a, wd, be, inj);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    applyWide(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    repeat (3) stepCycle();

    checkOutput("rst_ready", d8_ready, 1'b0);
    checkOutput("rst_busy", d8_busy, 1'b1);
    checkOutput("rst_rvalid", d8_rvalid, 1'b0);
    checkOutput("rst_rdata", d8_rdata, 8'h00);
    checkOutput("rst_perr", d8_perr, 1'b0);
    checkOutput("rst_rdata32", d32_rdata, 32'h0);

    rst_n = 1'b1;
    waitReady("init");

    // Freshly initialised array reads back INIT_VAL everywhere, back to back
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0);
      stepCycle();
      checkOutput("init_rd_valid", d8_rvalid, 1'b1);
      checkOutput("init_rd_data", d8_rdata, 8'h00);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    stepCycle();
    checkOutput("idle_rvalid", d8_rvalid, 1'b0);

    applyWide(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
    stepCycle();
    applyWide(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    checkOutput("init32_valid", d32_rvalid, 1'b1);
    checkOutput("init32_data", d32_rdata, 32'hDEADBEEF);

    write8(4'd3, 8'hA5, 1'b1, 1'b0);
    checkOutput("wr_no_rsp", d8_rvalid, 1'b0);
    read8("wr_rd", 4'd3, 8'hA5);
    write8(4'd3, 8'h5A, 1'b0, 1'b0);
    read8("be0_noop", 4'd3, 8'hA5);
    stepCycle();
    checkOutput("hold_valid", d8_rvalid, 1'b0);
    checkOutput("hold_data", d8_rdata, 8'hA5);

    applyWide(1'b1, 1'b1, 4'd5, 32'h11223344, 4'b1111);
    stepCycle();
    applyWide(1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'b0101);
    stepCycle();
    applyWide(1'b1, 1'b0, 4'd5, 32'h0, 4'b0000);
    stepCycle();
    applyWide(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    checkOutput("be32_valid", d32_rvalid, 1'b1);
    checkOutput("be32_data", d32_rdata, 32'h11FF33FF);

    for (int i = 0; i < 16; i++) begin
      model8[i] = 8'(i * 17 + 3);
      applyStimulus(1'b1, 1'b1, 4'(i), model8[i], 1'b1, 1'b0);
      stepCycle();
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0);
      stepCycle();
      checkOutput("b2b_valid", d8_rvalid, 1'b1);
      checkOutput("b2b_data", d8_rdata, model8[i]);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);

    // Write accepted together with clear, then the whole array is re-initialised
    applyStimulus(1'b1, 1'b1, 4'd7, 8'h77, 1'b1, 1'b0);
    clear = 1'b1;
    stepCycle();
    clear = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    checkOutput("clr_ready", d8_ready, 1'b0);
    waitReady("clear");
    read8("clr_rd7", 4'd7, 8'h00);
    read8("clr_rd3", 4'd3, 8'h00);
    applyWide(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    stepCycle();
    applyWide(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    checkOutput("clr32_data", d32_rdata, 32'hDEADBEEF);

    clear = 1'b1;
    stepCycle();
    clear = 1'b0;
    repeat (5) stepCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midinit_busy", d8_busy, 1'b1);
    checkOutput("midinit_ready", d8_ready, 1'b0);
    repeat (2) stepCycle();
    rst_n = 1'b1;
    waitReady("midinit");

    write8(4'd9, 8'h42, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd9, 8'h00, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midread_drop", d8_rvalid, 1'b0);
    checkOutput("midread_rdata", d8_rdata, 8'h00);
    stepCycle();
    rst_n = 1'b1;
    waitReady("midread");

    write8(4'd2, 8'h3C, 1'b1, 1'b1);
    read8("par_inj", 4'd2, 8'h3C);
`ifdef DMEM_PARITY_EN
    checkOutput("par_inj_perr", d8_perr, 1'b1);
`else
    checkOutput("par_inj_perr", d8_perr, 1'b0);
`endif
    write8(4'd2, 8'h3C, 1'b1, 1'b0);
    read8("par_ok", 4'd2, 8'h3C);
    checkOutput("par_ok_perr", d8_perr, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
